// File: rtl/nf2_dma_host_framer.sv
// Host DMA framer: turns host commands into txfifo request/data words and
// drains rxfifo packets back to the host, reporting length and error per command.
module nf2_dma_host_framer #(
   parameter int DMA_DATA_WIDTH = 32,
   parameter int NUM_CPU_QUEUES = 4,
   parameter int PKT_LEN_WIDTH  = 11
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_dir,
   input  logic [3:0]                   cmd_queue_id,
   input  logic [PKT_LEN_WIDTH-1:0]     cmd_len,
   input  logic [DMA_DATA_WIDTH-1:0]    host_tx_data,
   input  logic                         host_tx_vld,
   output logic                         host_tx_rdy,
   output logic [DMA_DATA_WIDTH-1:0]    host_rx_data,
   output logic                         host_rx_eop,
   output logic [1:0]                   host_rx_bytecnt,
   output logic                         host_rx_vld,
   input  logic                         host_rx_rdy,
   input  logic                         txfifo_full,
   output logic                         txfifo_wr,
   output logic [DMA_DATA_WIDTH+3:0]    txfifo_wr_data,
   input  logic                         rxfifo_empty,
   input  logic [DMA_DATA_WIDTH+2:0]    rxfifo_rd_data,
   output logic                         rxfifo_rd_inc,
   output logic                         xfer_done,
   output logic                         xfer_err,
   output logic [PKT_LEN_WIDTH-1:0]     xfer_len
);

   localparam int DW = DMA_DATA_WIDTH;
   localparam int LW = PKT_LEN_WIDTH;
   localparam logic [LW:0] LEN_MAX = {1'b0, {LW{1'b1}}};
   localparam logic [4:0]  NQ      = 5'(NUM_CPU_QUEUES);

   typedef enum logic [2:0] {IDLE, TX_REQ, TX_DATA, RX_REQ, RX_DATA, DONE} state_t;
   state_t state, state_nxt;

   logic          dir_q;
   logic [3:0]    qid_q;
   logic [LW-1:0] len_q;
   logic [LW-2:0] words_left;
   logic [LW-1:0] cnt_q;
   logic          rx_err_q;

   logic          cmd_bad, tx_eop, tx_fire, rx_eop, rx_fire, ovf;
   logic [LW:0]   len_p3, rx_sum;
   logic [2:0]    rx_add;
   logic [LW-1:0] cnt_nxt;

   // rx to an invalid queue would never see EOP from the board, so it fails locally
   assign cmd_bad = cmd_dir ? ({1'b0, cmd_queue_id} >= NQ) : (cmd_len == '0);
   assign len_p3  = {1'b0, cmd_len} + (LW+1)'(3);
   assign tx_eop  = (words_left == (LW-1)'(1));
   assign tx_fire = (state == TX_DATA) && host_tx_vld && !txfifo_full;
   assign rx_eop  = rxfifo_rd_data[DW+2];
   assign rx_fire = (state == RX_DATA) && !rxfifo_empty && host_rx_rdy;

   // EOP bytecnt 00 means a full word
   assign rx_add  = (rx_eop && rxfifo_rd_data[DW+1:DW] != 2'b00) ?
                    {1'b0, rxfifo_rd_data[DW+1:DW]} : 3'd4;
   assign rx_sum  = {1'b0, cnt_q} + {{(LW-2){1'b0}}, rx_add};
   assign ovf     = rx_sum > LEN_MAX;
   assign cnt_nxt = ovf ? {LW{1'b1}} : rx_sum[LW-1:0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = cmd_bad ? DONE : (cmd_dir ? RX_REQ : TX_REQ);
         TX_REQ:  if (!txfifo_full) state_nxt = TX_DATA;
         RX_REQ:  if (!txfifo_full) state_nxt = RX_DATA;
         TX_DATA: if (tx_fire && tx_eop) state_nxt = DONE;
         RX_DATA: if (rx_fire && rx_eop) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held so an abandoned transfer
   // cannot touch either FIFO in the reset cycle.
   always_comb begin
      cmd_ready       = 1'b0;
      host_tx_rdy     = 1'b0;
      host_rx_data    = '0;
      host_rx_eop     = 1'b0;
      host_rx_bytecnt = 2'b00;
      host_rx_vld     = 1'b0;
      txfifo_wr       = 1'b0;
      txfifo_wr_data  = '0;
      rxfifo_rd_inc   = 1'b0;
      xfer_done       = 1'b0;
      if (reset) begin
         cmd_ready = 1'b1;
      end else begin
         case (state)
            IDLE: cmd_ready = 1'b1;
            TX_REQ, RX_REQ: begin
               txfifo_wr      = !txfifo_full;
               txfifo_wr_data = {1'b1, dir_q, 2'b00, {(DW-4){1'b0}}, qid_q};
            end
            TX_DATA: begin
               host_tx_rdy    = !txfifo_full;
               txfifo_wr      = tx_fire;
               txfifo_wr_data = {1'b0, tx_eop, tx_eop ? len_q[1:0] : 2'b00, host_tx_data};
            end
            RX_DATA: begin
               host_rx_vld     = !rxfifo_empty;
               host_rx_data    = rxfifo_rd_data[DW-1:0];
               host_rx_eop     = rx_eop;
               host_rx_bytecnt = rxfifo_rd_data[DW+1:DW];
               rxfifo_rd_inc   = rx_fire;
            end
            DONE: xfer_done = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q      <= 1'b0;
         qid_q      <= '0;
         len_q      <= '0;
         words_left <= '0;
         cnt_q      <= '0;
         rx_err_q   <= 1'b0;
         xfer_err   <= 1'b0;
         xfer_len   <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               dir_q      <= cmd_dir;
               qid_q      <= cmd_queue_id;
               len_q      <= cmd_len;
               words_left <= (LW-1)'(len_p3 >> 2);
               cnt_q      <= '0;
               rx_err_q   <= 1'b0;
               if (cmd_bad) begin
                  xfer_err <= 1'b1;
                  xfer_len <= '0;
               end
            end
            TX_DATA: if (tx_fire) begin
               words_left <= words_left - 1'b1;
               if (tx_eop) begin
                  xfer_err <= 1'b0;
                  xfer_len <= len_q;
               end
            end
            RX_DATA: if (rx_fire) begin
               cnt_q    <= cnt_nxt;
               rx_err_q <= rx_err_q | ovf;
               if (rx_eop) begin
                  xfer_err <= rx_err_q | ovf;
                  xfer_len <= cnt_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nf2_dma_host_framer.sv
// Randomized bench for nf2_dma_host_framer: FIFO/host models plus a
// transaction-level reference checked every cycle.
module tb_nf2_dma_host_framer;
   localparam int DW = 32;
   localparam int LW = 11;
   localparam int NQ = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_dir;
   logic [3:0]    cmd_queue_id;
   logic [LW-1:0] cmd_len;
   logic [DW-1:0] host_tx_data;
   logic          host_tx_vld, host_tx_rdy;
   logic [DW-1:0] host_rx_data;
   logic          host_rx_eop;
   logic [1:0]    host_rx_bytecnt;
   logic          host_rx_vld, host_rx_rdy;
   logic          txfifo_full, txfifo_wr;
   logic [DW+3:0] txfifo_wr_data;
   logic          rxfifo_empty;
   logic [DW+2:0] rxfifo_rd_data;
   logic          rxfifo_rd_inc;
   logic          xfer_done, xfer_err;
   logic [LW-1:0] xfer_len;

   always #5 clk = ~clk;

   nf2_dma_host_framer #(.DMA_DATA_WIDTH(DW), .NUM_CPU_QUEUES(NQ), .PKT_LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_queue_id(cmd_queue_id), .cmd_len(cmd_len),
      .host_tx_data(host_tx_data), .host_tx_vld(host_tx_vld), .host_tx_rdy(host_tx_rdy),
      .host_rx_data(host_rx_data), .host_rx_eop(host_rx_eop), .host_rx_bytecnt(host_rx_bytecnt),
      .host_rx_vld(host_rx_vld), .host_rx_rdy(host_rx_rdy),
      .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr), .txfifo_wr_data(txfifo_wr_data),
      .rxfifo_empty(rxfifo_empty), .rxfifo_rd_data(rxfifo_rd_data), .rxfifo_rd_inc(rxfifo_rd_inc),
      .xfer_done(xfer_done), .xfer_err(xfer_err), .xfer_len(xfer_len)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: event occurred, required none", nm);
   endtask

   // host/FIFO contents and transaction-level expectation
   logic [DW-1:0] tx_src[$];
   logic [DW+2:0] rx_src[$];
   logic [DW+3:0] exp_tx[$];
   bit            busy, req_ph, tx_ph, rx_ph, done_due, cur_dir;
   logic          exp_err;
   logic [LW-1:0] exp_len;
   int            p_full = 0, p_vld = 100, p_rdy = 100, p_avail = 100;
   bit            full_toggle = 0;
   int            wr_cnt = 0, pop_cnt = 0, done_cnt = 0;
   logic [DW+3:0] last_wr, last_req;
   logic          last_err;
   logic [LW-1:0] last_len;

   bit            ev_acc, ev_wr, ev_hs, ev_pop, ev_rst;
   logic          acc_dir;
   logic [3:0]    acc_q;
   logic [LW-1:0] acc_len;

   task automatic accept_cmd();
      busy    = 1;
      cur_dir = acc_dir;
      if ((!acc_dir && acc_len == 0) || (acc_dir && int'(acc_q) >= NQ)) begin
         done_due = 1;
         exp_err  = 1'b1;
         exp_len  = '0;
      end else begin
         req_ph = 1;
         exp_tx.push_back({1'b1, acc_dir, 2'b00, 28'h0, acc_q});
         if (!acc_dir) begin
            int n = (int'(acc_len) + 3) / 4;
            for (int i = 0; i < n; i++) begin
               bit last = (i == n - 1);
               exp_tx.push_back({1'b0, last, last ? acc_len[1:0] : 2'b00, tx_src[i]});
            end
            exp_err = 1'b0;
            exp_len = acc_len;
         end else begin
            int sum = 0;
            foreach (rx_src[i]) begin
               if (rx_src[i][DW+2]) begin
                  sum += (rx_src[i][DW+1:DW] == 2'b00) ? 4 : int'(rx_src[i][DW+1:DW]);
                  break;
               end
               sum += 4;
            end
            exp_err = (sum > 2047);
            exp_len = (sum > 2047) ? 11'd2047 : LW'(sum);
         end
      end
   endtask

   // per-cycle model: observe at negedge, advance model and drive at posedge+1
   initial begin
      logic [DW+3:0] ew;
      txfifo_full = 0; host_tx_vld = 0; host_tx_data = '0;
      rxfifo_empty = 1; rxfifo_rd_data = '0; host_rx_rdy = 0;
      forever begin
         @(negedge clk);
         ev_acc = 0; ev_wr = 0; ev_hs = 0; ev_pop = 0; ev_rst = 0;
         if (reset) begin
            ev_rst = 1;
            chk("reset outputs", {cmd_ready, host_tx_rdy, host_rx_vld, txfifo_wr, rxfifo_rd_inc, xfer_done},
                6'b100000);
         end else begin
            chk("cmd_ready", cmd_ready, !busy);
            if (cmd_valid && cmd_ready) begin
               ev_acc = 1; acc_dir = cmd_dir; acc_q = cmd_queue_id; acc_len = cmd_len;
            end
            chk("host_tx_rdy", host_tx_rdy, tx_ph && !txfifo_full);
            chk("txfifo_wr", txfifo_wr, !txfifo_full && (req_ph || (tx_ph && host_tx_vld)));
            if (txfifo_wr && txfifo_full) fail("write while full");
            if (txfifo_wr) begin
               if (exp_tx.size() == 0) fail("unexpected tx word");
               else chk("tx word", txfifo_wr_data, exp_tx[0]);
               ev_wr = 1; last_wr = txfifo_wr_data;
            end
            ev_hs = host_tx_vld && host_tx_rdy;
            chk("host_rx_vld", host_rx_vld, rx_ph && !rxfifo_empty);
            if (host_rx_vld && rx_src.size() > 0)
               chk("host rx word", {host_rx_eop, host_rx_bytecnt, host_rx_data}, rx_src[0]);
            chk("rxfifo_rd_inc", rxfifo_rd_inc, rx_ph && !rxfifo_empty && host_rx_rdy);
            if (rxfifo_rd_inc && rxfifo_empty) fail("pop while empty");
            ev_pop = rxfifo_rd_inc;
            chk("xfer_done", xfer_done, done_due);
            if (xfer_done && done_due) begin
               chk("xfer_err", xfer_err, exp_err);
               chk("xfer_len", xfer_len, exp_len);
            end
            if (xfer_done) begin done_cnt++; last_err = xfer_err; last_len = xfer_len; end
         end
         @(posedge clk); #1;
         if (ev_rst) begin
            busy = 0; req_ph = 0; tx_ph = 0; rx_ph = 0; done_due = 0;
            exp_tx.delete();
         end else begin
            if (done_due) begin done_due = 0; busy = 0; end
            if (ev_acc) accept_cmd();
            if (ev_wr) begin
               wr_cnt++;
               ew = (exp_tx.size() > 0) ? exp_tx.pop_front() : '0;
               if (req_ph) begin
                  req_ph = 0; last_req = last_wr;
                  if (cur_dir) rx_ph = 1; else tx_ph = 1;
               end else if (ew[DW+2]) begin
                  tx_ph = 0; done_due = 1;
               end
            end
            if (ev_hs && tx_src.size() > 0) void'(tx_src.pop_front());
            if (ev_pop) begin
               pop_cnt++;
               if (rx_src.size() > 0) begin
                  if (rx_src[0][DW+2]) begin rx_ph = 0; done_due = 1; end
                  void'(rx_src.pop_front());
               end
            end
         end
         txfifo_full    = full_toggle ? !txfifo_full : ($urandom_range(99) < p_full);
         host_tx_vld    = (tx_src.size() > 0) && ($urandom_range(99) < p_vld);
         host_tx_data   = (tx_src.size() > 0) ? tx_src[0] : '0;
         rxfifo_empty   = !((rx_src.size() > 0) && ($urandom_range(99) < p_avail));
         rxfifo_rd_data = (rx_src.size() > 0) ? rx_src[0] : '0;
         host_rx_rdy    = $urandom_range(99) < p_rdy;
      end
   end

   logic [DW-1:0] gen_last;

   task automatic do_reset(input int n);
      @(posedge clk); #1 reset = 1;
      repeat (n) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic send_cmd(input logic d, input logic [3:0] q, input logic [LW-1:0] len);
      bit ok = 0;
      @(posedge clk); #1;
      cmd_valid = 1; cmd_dir = d; cmd_queue_id = q; cmd_len = len;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1;
      end
      if (!ok) fail("cmd accept timeout");
      @(posedge clk); #1 cmd_valid = 0;
   endtask

   task automatic wait_done();
      int st = done_cnt;
      bit got = 0;
      for (int i = 0; i < 6000 && !got; i++) begin
         @(posedge clk);
         if (done_cnt > st) got = 1;
      end
      if (!got) fail("xfer_done timeout");
      @(posedge clk);
   endtask

   task automatic run_tx(input logic [3:0] q, input logic [LW-1:0] len);
      int n = (int'(len) + 3) / 4;
      for (int i = 0; i < n; i++) begin
         gen_last = $urandom();
         tx_src.push_back(gen_last);
      end
      send_cmd(1'b0, q, len);
      wait_done();
   endtask

   task automatic load_rx(input int nwords, input logic [1:0] lastbc);
      for (int i = 0; i < nwords; i++) begin
         logic [1:0] bc = (i == nwords - 1) ? lastbc : 2'($urandom_range(3));
         rx_src.push_back({(i == nwords - 1), bc, DW'($urandom())});
      end
   endtask

   int w0, p0, d0;

   initial begin
      reset = 1; cmd_valid = 0; cmd_dir = 0; cmd_queue_id = '0; cmd_len = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("reset xfer_len", xfer_len, 0);
      chk("reset xfer_err", xfer_err, 0);
      chk("reset cmd_ready", cmd_ready, 1);

      // tx q2 len 9
      w0 = wr_cnt;
      run_tx(4'd2, 11'd9);
      chk("tx9 req word", last_req, 36'h8_0000_0002);
      chk("tx9 eop word", last_wr, {4'h5, gen_last});
      chk("tx9 writes", wr_cnt - w0, 4);
      chk("tx9 len", last_len, 9);
      chk("tx9 err", last_err, 0);

      // tx len 8 against a txfifo_full toggling every cycle
      full_toggle = 1; w0 = wr_cnt;
      run_tx(4'd3, 11'd8);
      full_toggle = 0;
      chk("tx8 eop nibble", last_wr[DW+3:DW], 4'h4);
      chk("tx8 writes", wr_cnt - w0, 3);
      chk("tx8 len", last_len, 8);

      // rx q1, 3 words ending bc=10, host stalls
      p_rdy = 50; p0 = pop_cnt;
      load_rx(3, 2'b10);
      send_cmd(1'b1, 4'd1, 11'd0);
      wait_done();
      p_rdy = 100;
      chk("rx q1 req word", last_req, 36'hC_0000_0001);
      chk("rx q1 len", last_len, 10);
      chk("rx q1 err", last_err, 0);
      chk("rx q1 pops", pop_cnt - p0, 3);

      // invalid rx queue and zero-length tx both fail without FIFO traffic
      w0 = wr_cnt; p0 = pop_cnt;
      load_rx(2, 2'b00);
      send_cmd(1'b1, 4'd5, 11'd0);
      wait_done();
      rx_src.delete();
      chk("rx q5 writes", wr_cnt - w0, 0);
      chk("rx q5 pops", pop_cnt - p0, 0);
      chk("rx q5 err", last_err, 1);
      chk("rx q5 len", last_len, 0);
      run_tx(4'd0, 11'd0);
      chk("tx len0 writes", wr_cnt - w0, 0);
      chk("tx len0 err", last_err, 1);
      chk("tx len0 len", last_len, 0);

      // 600-word rx packet saturates the length
      p_rdy = 80; p_avail = 80; p0 = pop_cnt;
      load_rx(600, 2'($urandom_range(3)));
      send_cmd(1'b1, 4'd0, 11'd0);
      wait_done();
      p_rdy = 100; p_avail = 100;
      chk("rx600 len", last_len, 2047);
      chk("rx600 err", last_err, 1);
      chk("rx600 pops", pop_cnt - p0, 600);

      // reset while a tx is mid-stream, then a clean short tx
      d0 = done_cnt;
      for (int i = 0; i < 10; i++) tx_src.push_back(DW'($urandom()));
      send_cmd(1'b0, 4'd3, 11'd40);
      repeat (4) @(posedge clk);
      do_reset(2);
      tx_src.delete();
      chk("mid-reset no done", done_cnt - d0, 0);
      w0 = wr_cnt;
      repeat (5) @(posedge clk);
      chk("post-reset idle writes", wr_cnt - w0, 0);
      run_tx(4'd0, 11'd4);
      chk("post-reset req", last_req, 36'h8_0000_0000);
      chk("post-reset eop word", last_wr, {4'h4, gen_last});
      chk("post-reset writes", wr_cnt - w0, 2);

      // randomized mix
      for (int t = 0; t < 40; t++) begin
         p_full  = $urandom_range(50);
         p_vld   = 50 + $urandom_range(50);
         p_rdy   = 40 + $urandom_range(60);
         p_avail = 40 + $urandom_range(60);
         if ($urandom_range(1) == 0) begin
            logic [LW-1:0] len = ($urandom_range(7) == 0) ? 11'd0 : 11'(1 + $urandom_range(63));
            run_tx(4'($urandom_range(7)), len);
         end else begin
            logic [3:0] q = 4'($urandom_range(5));
            load_rx(1 + $urandom_range(15), 2'($urandom_range(3)));
            send_cmd(1'b1, q, 11'($urandom_range(100)));
            wait_done();
            rx_src.delete();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
